instruction_fetch_stage: RTL and testbench
==========================================

Name: instruction_fetch_stage

Overview:
- Fetch stage wrapped around the 32-bit program counter register.
- Each cycle it takes the current PC (PCResult) and the instruction-memory word read at that PC, and buffers the pair in a small FIFO queue toward decode.
- It computes the next Address fed back to the PC register: sequential +4, hold on a full queue, or redirect on a taken branch/jump.
- A taken redirect also flushes the queue.

Parameters:
- DEPTH, 2, number of fetch-queue entries (power of two, ≥2).
- CNT_W, 2, width of QueueCount; must hold values 0..DEPTH.

Ports:
- Clk, input, 1, rising-edge clock.
- Reset, input, 1, synchronous active-high reset.
- PCResult, input, 32, current PC from the PC register.
- Instruction, input, 32, instruction-memory word at PCResult (combinational read).
- BranchTaken, input, 1, redirect request from execute.
- BranchTarget, input, 32, redirect target address.
- DecodeReady, input, 1, decode accepts the head entry this cycle.
- Address, output, 32, next-PC value to the PC register (combinational).
- IF_Valid, output, 1, head entry is valid.
- IF_Instruction, output, 32, head instruction.
- IF_PC, output, 32, head entry's PC.
- IF_PCPlus4, output, 32, head PC + 4.
- QueueCount, output, CNT_W, number of occupied entries.
- StallCycles, output, 32, count of cycles with IF_Valid=1 and DecodeReady=0.

Behaviour:
- One clock domain; all state updates on posedge Clk; Reset is synchronous and active-high.
- Reset high at an edge:
  - Queue emptied; read/write pointers and QueueCount go to 0.
  - StallCycles goes to 0.
  - IF_Valid=0; IF_Instruction, IF_PC and IF_PCPlus4 read 0.
- While Reset is high, Address is driven to 0x00000000.
- Enqueue condition (enq): Reset=0, BranchTaken=0 and QueueCount<DEPTH. It uses the registered count only, with no path from DecodeReady.
- Dequeue condition (deq): IF_Valid=1, DecodeReady=1 and BranchTaken=0.
- Address selection, in priority order:
  - Reset → 0.
  - BranchTaken → {BranchTarget[31:2], 2'b00}.
  - enq → PCResult + 4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
  - Otherwise → PCResult, so the PC holds.
- On enq, the entry {PCResult, Instruction} is written at the write pointer.
- enq and deq in the same cycle are both performed, and the count is unchanged.
- Steady-state throughput: 1 instruction/cycle whenever decode keeps accepting.
- Fetch latency: the instruction at PC p appears at IF_* no earlier than the edge after PCResult=p.
- Head outputs are driven combinationally from the read-pointer entry. When the queue is empty, IF_Valid=0 and IF_Instruction/IF_PC/IF_PCPlus4 read 0.
- IF_PCPlus4 = IF_PC + 4, modulo 2^32.
- BranchTaken=1 at an edge:
  - All entries are discarded, count goes to 0, and pointers go to 0.
  - The same-cycle PCResult/Instruction pair is not enqueued.
  - No dequeue is reported, and decode must ignore the head that cycle.
  - On the next cycle PCResult equals the aligned target, and fetch resumes from it.
- Full (QueueCount=DEPTH) and no deq: Address=PCResult, so the PC is frozen and no word is lost or duplicated.
- Full with deq: no enq this cycle, so the count drops to DEPTH-1; enq resumes on the following cycle.
- Empty with DecodeReady=1: nothing happens and IF_Valid stays 0.
- Pointers wrap modulo DEPTH.
- StallCycles increments on each edge where IF_Valid=1 and DecodeReady=0, saturates at 0xFFFFFFFF, and is cleared only by Reset.
- Reset asserted mid-stream takes precedence over BranchTaken and over all queue activity.

Test Plan:
1. Reset for 2 cycles, then release, with DecodeReady=1 and memory returning word = PC ^ 0xA5A50000 → Address sequence 0, 4, 8, 12…; IF_PC 0, 4, 8 appear one per cycle starting the cycle after release+1; IF_PCPlus4 = IF_PC+4.
2. DecodeReady=0 from the start, DEPTH=2 → QueueCount climbs to 2, then Address holds at 0x8 while PCResult=0x8. Raise DecodeReady → entries PC 0x0 and 0x4 drain in order, then 0x8 follows with no gap or duplicate. StallCycles equals the number of held cycles.
3. Queue holding PC 0x10 and 0x14, assert BranchTaken with BranchTarget=0x0000_0103 for 1 cycle → next cycle QueueCount=0 and IF_Valid=0. Address was 0x100; the next enqueued PC is 0x100.
4. BranchTaken with the queue full and DecodeReady=1 in the same cycle → flush wins, no dequeue counted, QueueCount=0.
5. PC register preset so PCResult=0xFFFFFFFC with an empty queue → Address=0x00000000, and the head shows IF_PC=0xFFFFFFFC, IF_PCPlus4=0x0.
6. Reset asserted while the queue is full and BranchTaken=1 → next cycle everything is 0, Address=0 during reset, StallCycles=0.

Source files
------------

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: proposes the next PC and buffers {PC, instruction} pairs in a
// small FIFO toward decode. A taken branch redirects the PC and flushes the queue.
module instruction_fetch_stage #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 2
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [31:0]      PCResult,
    input  logic [31:0]      Instruction,
    input  logic             BranchTaken,
    input  logic [31:0]      BranchTarget,
    input  logic             DecodeReady,
    output logic [31:0]      Address,
    output logic             IF_Valid,
    output logic [31:0]      IF_Instruction,
    output logic [31:0]      IF_PC,
    output logic [31:0]      IF_PCPlus4,
    output logic [CNT_W-1:0] QueueCount,
    output logic [31:0]      StallCycles
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [31:0]      pc_mem_q    [DEPTH];
    logic [31:0]      instr_mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      stall_q, stall_d;
    logic             if_valid;
    logic             enq;
    logic             deq;

    // Enqueue looks only at the registered count so DecodeReady never feeds Address.
    assign if_valid = (count_q != '0);
    assign enq      = !Reset && !BranchTaken && (count_q < FULL_CNT);
    assign deq      = if_valid && DecodeReady && !BranchTaken;

    always_comb begin
        Address = PCResult;
        if (Reset) begin
            Address = 32'h0000_0000;
        end else if (BranchTaken) begin
            Address = BranchTarget & 32'hFFFF_FFFC;
        end else if (enq) begin
            Address = PCResult + 32'd4;
        end
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (BranchTaken) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (enq) begin
                wptr_d = wptr_q + 1'b1;
            end
            if (deq) begin
                rptr_d = rptr_q + 1'b1;
            end
            if (enq && !deq) begin
                count_d = count_q + 1'b1;
            end else if (!enq && deq) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (if_valid && !DecodeReady && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            stall_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            stall_q <= stall_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (enq) begin
            pc_mem_q[wptr_q]    <= PCResult;
            instr_mem_q[wptr_q] <= Instruction;
        end
    end

    assign IF_Valid       = if_valid;
    assign IF_PC          = if_valid ? pc_mem_q[rptr_q] : 32'h0;
    assign IF_Instruction = if_valid ? instr_mem_q[rptr_q] : 32'h0;
    assign IF_PCPlus4     = if_valid ? (pc_mem_q[rptr_q] + 32'd4) : 32'h0;
    assign QueueCount     = count_q;
    assign StallCycles    = stall_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: owns the PC register and instruction memory,
// checks every cycle against a queue-based reference model plus directed vectors.
module tb_instruction_fetch_stage;

    localparam int DEPTH = 2;
    localparam int CNT_W = 2;

    logic             Clk;
    logic             Reset;
    logic [31:0]      PCResult;
    logic [31:0]      Instruction;
    logic             BranchTaken;
    logic [31:0]      BranchTarget;
    logic             DecodeReady;
    logic [31:0]      Address;
    logic             IF_Valid;
    logic [31:0]      IF_Instruction;
    logic [31:0]      IF_PC;
    logic [31:0]      IF_PCPlus4;
    logic [CNT_W-1:0] QueueCount;
    logic [31:0]      StallCycles;

    instruction_fetch_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .PCResult       (PCResult),
        .Instruction    (Instruction),
        .BranchTaken    (BranchTaken),
        .BranchTarget   (BranchTarget),
        .DecodeReady    (DecodeReady),
        .Address        (Address),
        .IF_Valid       (IF_Valid),
        .IF_Instruction (IF_Instruction),
        .IF_PC          (IF_PC),
        .IF_PCPlus4     (IF_PCPlus4),
        .QueueCount     (QueueCount),
        .StallCycles    (StallCycles)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    typedef struct {
        bit          r;
        bit          dr;
        logic [31:0] addr;
        bit          valid;
        logic [31:0] pc;
        logic [1:0]  cnt;
        logic [31:0] stall;
    } vec_t;

    ent_t        mq[$];
    logic [31:0] m_stall;
    logic [31:0] pc_reg;
    logic [31:0] e_addr;
    bit          cur_r, cur_bt, cur_dr, cur_v, cur_enq;
    int          n_checks;
    int          n_fail;
    int          cyc;
    vec_t        vt[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs from the bench PC register and compare against the model.
    task automatic drive_and_check(input bit r, input bit bt, input logic [31:0] tgt, input bit dr);
        logic [31:0] e_pc, e_ins, e_p4;
        Reset        = r;
        BranchTaken  = bt;
        BranchTarget = tgt;
        DecodeReady  = dr;
        PCResult     = pc_reg;
        Instruction  = pc_reg ^ 32'hA5A5_0000;
        #1;
        cur_r   = r;
        cur_bt  = bt;
        cur_dr  = dr;
        cur_v   = (mq.size() > 0);
        cur_enq = !r && !bt && (mq.size() < DEPTH);
        e_pc    = cur_v ? mq[0].pc : 32'h0;
        e_ins   = cur_v ? mq[0].ins : 32'h0;
        e_p4    = cur_v ? (mq[0].pc + 32'd4) : 32'h0;
        if (r)            e_addr = 32'h0;
        else if (bt)      e_addr = {tgt[31:2], 2'b00};
        else if (cur_enq) e_addr = pc_reg + 32'd4;
        else              e_addr = pc_reg;
        chk("Address", Address, e_addr);
        chk("IF_Valid", 32'(IF_Valid), 32'(cur_v));
        chk("IF_PC", IF_PC, e_pc);
        chk("IF_Instruction", IF_Instruction, e_ins);
        chk("IF_PCPlus4", IF_PCPlus4, e_p4);
        chk("QueueCount", 32'(QueueCount), 32'(mq.size()));
        chk("StallCycles", StallCycles, m_stall);
        $display("cyc %0d rst=%0b bt=%0b dr=%0b pc=%h addr=%h valid=%0b if_pc=%h cnt=%0d stall=%0d",
                 cyc, r, bt, dr, pc_reg, Address, IF_Valid, IF_PC, QueueCount, StallCycles);
        cyc++;
    endtask

    task automatic tick();
        ent_t e;
        if (cur_r) begin
            mq.delete();
            m_stall = 32'h0;
        end else begin
            if (cur_v && !cur_dr && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
            if (cur_bt) begin
                mq.delete();
            end else begin
                if (cur_v && cur_dr) void'(mq.pop_front());
                if (cur_enq) begin
                    e.pc  = pc_reg;
                    e.ins = pc_reg ^ 32'hA5A5_0000;
                    mq.push_back(e);
                end
            end
        end
        pc_reg = e_addr;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        m_stall  = 32'h0;
        pc_reg   = 32'h0;
        mq.delete();

        //        r  dr addr     v  pc      cnt stall
        vt[0]  = '{1, 1, 32'd0,  0, 32'd0,  0, 0};
        vt[1]  = '{0, 1, 32'd4,  0, 32'd0,  0, 0};
        vt[2]  = '{0, 1, 32'd8,  1, 32'd0,  1, 0};
        vt[3]  = '{0, 1, 32'd12, 1, 32'd4,  1, 0};
        vt[4]  = '{0, 1, 32'd16, 1, 32'd8,  1, 0};
        vt[5]  = '{1, 0, 32'd0,  1, 32'd12, 1, 0};
        vt[6]  = '{0, 0, 32'd4,  0, 32'd0,  0, 0};
        vt[7]  = '{0, 0, 32'd8,  1, 32'd0,  1, 0};
        vt[8]  = '{0, 0, 32'd8,  1, 32'd0,  2, 1};
        vt[9]  = '{0, 0, 32'd8,  1, 32'd0,  2, 2};
        vt[10] = '{0, 1, 32'd8,  1, 32'd0,  2, 3};
        vt[11] = '{0, 1, 32'd12, 1, 32'd4,  1, 3};
        vt[12] = '{0, 1, 32'd16, 1, 32'd8,  1, 3};

        Reset        = 1'b1;
        BranchTaken  = 1'b0;
        BranchTarget = 32'h0;
        DecodeReady  = 1'b0;
        PCResult     = 32'h0;
        Instruction  = 32'h0;
        @(posedge Clk);
        #1;

        // Reset release, streaming, then a full-queue hold and drain.
        for (int i = 0; i < 13; i++) begin
            drive_and_check(vt[i].r, 1'b0, 32'h0, vt[i].dr);
            chk("vec_addr", Address, vt[i].addr);
            chk("vec_valid", 32'(IF_Valid), 32'(vt[i].valid));
            chk("vec_pc", IF_PC, vt[i].pc);
            chk("vec_cnt", 32'(QueueCount), 32'(vt[i].cnt));
            chk("vec_stall", StallCycles, vt[i].stall);
            tick();
        end

        // Redirect flushes a queue holding 0x10 and 0x14.
        drive_and_check(1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        pc_reg = 32'h10;
        drive_and_check(1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        drive_and_check(1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        drive_and_check(1'b0, 1'b1, 32'h0000_0103, 1'b0);
        chk("t3_head_pc", IF_PC, 32'h10);
        chk("t3_full", 32'(QueueCount), 32'd2);
        chk("t3_addr", Address, 32'h100);
        tick();
        drive_and_check(1'b0, 1'b0, 32'h0, 1'b0);
        chk("t3_cnt", 32'(QueueCount), 32'd0);
        chk("t3_valid", 32'(IF_Valid), 32'd0);
        tick();
        drive_and_check(1'b0, 1'b0, 32'h0, 1'b0);
        chk("t3_next_pc", IF_PC, 32'h100);
        tick();

        // Flush wins over a same-cycle dequeue on a full queue.
        drive_and_check(1'b0, 1'b1, 32'h40, 1'b1);
        chk("t4_full", 32'(QueueCount), 32'd2);
        tick();
        drive_and_check(1'b0, 1'b0, 32'h0, 1'b1);
        chk("t4_cnt", 32'(QueueCount), 32'd0);
        chk("t4_pc", pc_reg, 32'h40);
        tick();

        // PC wrap at the top of the address space.
        drive_and_check(1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        pc_reg = 32'hFFFF_FFFC;
        drive_and_check(1'b0, 1'b0, 32'h0, 1'b0);
        chk("t5_addr", Address, 32'h0);
        tick();
        drive_and_check(1'b0, 1'b0, 32'h0, 1'b0);
        chk("t5_if_pc", IF_PC, 32'hFFFF_FFFC);
        chk("t5_pcplus4", IF_PCPlus4, 32'h0);
        tick();

        // Reset beats a branch on a full queue with pending stalls.
        drive_and_check(1'b1, 1'b1, 32'h0000_0200, 1'b0);
        chk("t6_full", 32'(QueueCount), 32'd2);
        chk("t6_addr", Address, 32'h0);
        tick();
        drive_and_check(1'b0, 1'b0, 32'h0, 1'b0);
        chk("t6_cnt", 32'(QueueCount), 32'd0);
        chk("t6_valid", 32'(IF_Valid), 32'd0);
        chk("t6_stall", StallCycles, 32'd0);
        chk("t6_if_pc", IF_PC, 32'd0);
        tick();

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            bit          r, bt, dr;
            logic [31:0] tgt;
            r   = ($urandom_range(0, 39) == 0);
            bt  = ($urandom_range(0, 7) == 0);
            dr  = ($urandom_range(0, 1) == 1);
            tgt = $urandom;
            drive_and_check(r, bt, tgt, dr);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
